pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised elastic pipeline register: the successor to the fixed-width inter-stage registers between the IF/ID/EX/MEM/WB stages. It carries an arbitrary-width payload with a valid bit, a valid/ready handshake replacing the single write-enable, a flush that inserts a bubble, and saturating stall/flush event counters for performance analysis. One instance sits between every pair of adjacent pipeline stages.

## Interface
Parameters:
- DATA_W, 66, payload width in bits (default fits pcSel 2 + opcode 32 + NPC 32)
- BUBBLE_VAL, 0, payload value held whenever the stage is empty (reset, flush, drain); for example, a NOP encoding
- CNT_W, 16, width of each event counter

Ports (all sampled and driven on the rising edge of clk):
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset; highest priority
- in_valid  in  1  upstream presents a payload
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  stage accepts the payload this cycle
- out_valid  out  1  stage holds a valid payload
- out_data  out  DATA_W  registered payload
- out_ready  in  1  downstream consumes; deassert to stall (hazard unit)
- flush  in  1  discard held payload(s) and insert a bubble
- cnt_clr  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- flush_cnt  out  CNT_W  flush cycles that discarded at least one valid entry

## Operation
- Transfers: upstream accepts when in_valid && in_ready; downstream accepts when out_valid && out_ready.
- Priority per cycle: rst > flush > normal update.
- rst: out_valid=0, out_data=BUBBLE_VAL, skid empty, both counters 0.
- flush: out_valid=0, out_data=BUBBLE_VAL, skid emptied; any in_data accepted in the same cycle is dropped; in_ready is unaffected combinationally.
- Normal update (base build):
  - in_ready = out_ready || !out_valid.
  - On upstream accept, the payload loads into out_data and out_valid is set to 1.
  - Else, if out_ready && out_valid, the stage drains: out_valid goes to 0 and out_data goes to BUBBLE_VAL.
  - Else, the stage holds its payload unchanged.
- Counters:
  - stall_cnt increments when out_valid && !out_ready && !flush.
  - flush_cnt increments when flush && (out_valid || skid valid).
  - Both counters saturate at 2^CNT_W−1 with no wrap.
  - cnt_clr zeroes both counters and has priority over increments in the same cycle. rst also clears them.

## Timing
- Latency is 1 cycle from upstream accept to out_valid/out_data.
- Full throughput: one transfer per cycle with out_ready held high.
- Base build: in_ready is combinational from out_ready and out_valid.
- The payload is never modified while out_valid && !out_ready.
- The bubble appears on out_data in the cycle after flush is sampled.
- Reset asserted mid-stall clears the stage the next edge. The held payload is lost, not replayed.
- A simultaneous flush and upstream accept leaves the stage empty.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Adds a one-entry skid register. in_ready becomes a registered signal equal to !skid_valid, so there is no combinational out_ready→in_ready path.
  - If upstream transfers while the main stage is valid and !out_ready, the payload goes into the skid entry and in_ready drops the next cycle.
  - On the next downstream accept, the skid entry moves into the main stage (same cycle edge) and in_ready rises the next cycle.
  - Ordering is preserved. Skid contents never appear on out_data before the main entry is consumed.
  - flush empties the skid entry.
- PIPE_STAGE_SKID_EN undefined: no skid register; in_ready behaves as in the base build.

## Test plan
- Reset with DATA_W=66, BUBBLE_VAL=0: hold rst for 2 cycles with in_valid=1 → out_valid=0, out_data=0, stall_cnt=0, flush_cnt=0, in_ready=1.
- Streaming: with out_ready=1, send 0x1, 0x2, 0x3 on consecutive cycles → out_data is 0x1, 0x2, 0x3 one cycle later each, out_valid=1 for 3 cycles, then 0 with out_data=BUBBLE_VAL.
- Stall: load 0xAB, hold out_ready=0 for 4 cycles while presenting 0xCD → out_data stays 0xAB and stall_cnt=4.
  - Base build: in_ready=0 during the stall.
  - Skid build: 0xCD is captured into skid and in_ready=0 from the second cycle; after out_ready=1, 0xAB then 0xCD are output in order.
- Flush: with the stage valid holding 0x55, assert flush together with in_valid=1 and in_data=0x66 → next cycle out_valid=0, out_data=BUBBLE_VAL, flush_cnt=1. A flush while empty leaves flush_cnt unchanged.
- Saturation and clear: with CNT_W=2, stall for 6 cycles → stall_cnt=3. Assert cnt_clr on the same cycle as a stall → stall_cnt=0.
- Reset mid-stall: set rst=1 while a payload is held and out_ready=0 → next cycle out_valid=0, and no stale payload appears after release.

Source files
------------

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage
//  Purpose  : Elastic pipeline register with valid/ready handshake, flush
//             (bubble insertion) and saturating stall/flush event counters.
//             Sits between every pair of adjacent pipeline stages.
//  Macro    : PIPE_STAGE_SKID_EN - adds a one-entry skid buffer so that
//             in_ready is registered (no out_ready -> in_ready comb path).
//  Ports    : clk, rst (sync, active high)
//             in_valid / in_data / in_ready    - upstream handshake
//             out_valid / out_data / out_ready - downstream handshake
//             flush      - drop held payload(s), insert a bubble
//             cnt_clr    - synchronous clear of both counters
//             stall_cnt  - cycles with out_valid && !out_ready
//             flush_cnt  - flushes that discarded at least one valid entry
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int                DATA_W     = 66,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_in_ready;
    logic              w_up_acc;
    logic              w_dn_acc;
    logic              w_skid_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_up_acc  = in_valid && w_in_ready;
    assign w_dn_acc  = r_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

    // Ready depends only on skid occupancy: any transfer accepted while the
    // main entry is stalled lands in the skid slot, so there is always room.
    assign w_in_ready   = !r_skid_valid;
    assign w_skid_valid = r_skid_valid;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid      <= 1'b0;
            r_data       <= BUBBLE_VAL;
            r_skid_valid <= 1'b0;
            r_skid_data  <= BUBBLE_VAL;
        end else if (w_dn_acc || !r_valid) begin
            // Main entry is free after this edge.
            if (r_skid_valid) begin
                // Older skid entry goes first; in_ready was low, so no
                // upstream transfer can happen in this cycle.
                r_valid      <= 1'b1;
                r_data       <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_data  <= BUBBLE_VAL;
            end else if (w_up_acc) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
            end else if (w_dn_acc) begin
                r_valid <= 1'b0;
                r_data  <= BUBBLE_VAL;
            end
        end else if (w_up_acc) begin
            // Main entry stalled: park the new payload in the skid slot.
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
        end
    end
`else
    assign w_in_ready   = out_ready || !r_valid;
    assign w_skid_valid = 1'b0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE_VAL;
        end else if (w_up_acc) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (w_dn_acc) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE_VAL;
        end
    end
`endif

    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_valid && !out_ready && !flush && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
            if (flush && (r_valid || w_skid_valid) && (r_flush_cnt != C_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage
//  Purpose  : Directed, table-driven bench for pipe_stage. A second instance
//             with CNT_W=2 and a non-zero bubble shares all inputs so that
//             counter saturation and bubble insertion are checked together.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage;

    localparam int          DW     = 66;
    localparam logic [65:0] S_BUB  = 66'h3F;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, flush, cnt_clr;
    logic [DW-1:0] in_data;
    logic          ov, ir, s_ov, s_ir;
    logic [DW-1:0] od, s_od;
    logic [15:0]   sc, fc;
    logic [1:0]    s_sc, s_fc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(DW), .BUBBLE_VAL('0), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir), .out_valid(ov), .out_data(od), .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(sc), .flush_cnt(fc)
    );

    pipe_stage #(.DATA_W(DW), .BUBBLE_VAL(S_BUB), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_ir), .out_valid(s_ov), .out_data(s_od), .out_ready(out_ready),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    typedef struct {
        logic        rst, iv;
        logic [65:0] id;
        logic        ordy, fl, clr;
        logic        ov;
        logic [65:0] od;
        logic        ir, chk_ir;
        int          sc, fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [65:0] id,
                       input logic ordy, input logic fl, input logic clr,
                       input logic eov, input logic [65:0] eod,
                       input logic eir, input logic chk, input int esc, input int efc);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.ov = eov; v.od = eod; v.ir = eir; v.chk_ir = chk; v.sc = esc; v.fc = efc;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input logic [65:0] id,
                       input logic ordy, input logic fl, input logic clr);
        rst = r; in_valid = iv; in_data = id; out_ready = ordy; flush = fl; cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // Checks both instances against one expectation; the small one saturates
    // at 3 and shows its own bubble value when empty.
    task automatic check_all(input string nm, input logic eov, input logic [65:0] eod,
                             input int esc, input int efc);
        check({nm, " ov"}, ov, eov);
        check({nm, " od"}, od, eod);
        check({nm, " sc"}, sc, esc);
        check({nm, " fc"}, fc, efc);
        check({nm, " s_od"}, s_od, eov ? eod : S_BUB);
        check({nm, " s_sc"}, s_sc, (esc > 3) ? 3 : esc);
        check({nm, " s_fc"}, s_fc, (efc > 3) ? 3 : efc);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush = 1'b0; cnt_clr = 1'b0;

        //   rst iv  id                       ordy fl clr | ov od                      ir chk sc fc
        // reset held 2 cycles with in_valid high
        add(1, 1, 66'h77,                   1, 0, 0,   0, 66'h0,                   1, 1, 0, 0);
        add(1, 1, 66'h77,                   1, 0, 0,   0, 66'h0,                   1, 1, 0, 0);
        // streaming, 1-cycle latency, wide payload
        add(0, 1, 66'h1,                    1, 0, 0,   1, 66'h1,                   1, 1, 0, 0);
        add(0, 1, 66'h2_DEAD_BEEF_1234_5678, 1, 0, 0,  1, 66'h2_DEAD_BEEF_1234_5678, 1, 1, 0, 0);
        add(0, 1, 66'h3,                    1, 0, 0,   1, 66'h3,                   1, 1, 0, 0);
        add(0, 0, 66'h0,                    1, 0, 0,   0, 66'h0,                   1, 1, 0, 0);
        // stall 6 cycles: payload frozen, counters saturate on small instance
        add(0, 1, 66'hAB,                   1, 0, 0,   1, 66'hAB,                  1, 1, 0, 0);
        add(0, 0, 66'h0,                    0, 0, 0,   1, 66'hAB,                  0, 0, 1, 0);
        add(0, 0, 66'h0,                    0, 0, 0,   1, 66'hAB,                  0, 0, 2, 0);
        add(0, 0, 66'h0,                    0, 0, 0,   1, 66'hAB,                  0, 0, 3, 0);
        add(0, 0, 66'h0,                    0, 0, 0,   1, 66'hAB,                  0, 0, 4, 0);
        add(0, 0, 66'h0,                    0, 0, 0,   1, 66'hAB,                  0, 0, 5, 0);
        add(0, 0, 66'h0,                    0, 0, 0,   1, 66'hAB,                  0, 0, 6, 0);
        // clear during a stall cycle wins
        add(0, 0, 66'h0,                    0, 0, 1,   1, 66'hAB,                  0, 0, 0, 0);
        add(0, 0, 66'h0,                    1, 0, 0,   0, 66'h0,                   1, 1, 0, 0);
        // flush with simultaneous accept drops the new payload
        add(0, 1, 66'h55,                   0, 0, 0,   1, 66'h55,                  0, 0, 0, 0);
        add(0, 1, 66'h66,                   0, 1, 0,   0, 66'h0,                   1, 1, 0, 1);
        add(0, 0, 66'h0,                    1, 1, 0,   0, 66'h0,                   1, 1, 0, 1);
        add(0, 1, 66'h99,                   1, 0, 0,   1, 66'h99,                  1, 1, 0, 1);
        add(0, 0, 66'h0,                    1, 1, 0,   0, 66'h0,                   1, 1, 0, 2);
        add(0, 1, 66'h12,                   1, 0, 0,   1, 66'h12,                  1, 1, 0, 2);
        add(0, 0, 66'h0,                    1, 1, 1,   0, 66'h0,                   1, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
            check_all($sformatf("v%0d", i), vecs[i].ov, vecs[i].od, vecs[i].sc, vecs[i].fc);
            if (vecs[i].chk_ir) check($sformatf("v%0d ir", i), ir, vecs[i].ir);
        end

        // Reset mid-stall: held payload lost, nothing replayed after release.
        cyc(0, 1, 66'hC3, 1, 0, 0);
        check_all("rst_stall load", 1'b1, 66'hC3, 0, 0);
        cyc(0, 0, 66'h0, 0, 0, 0);
        check_all("rst_stall hold", 1'b1, 66'hC3, 1, 0);
        cyc(1, 0, 66'h0, 0, 0, 0);
        check_all("rst_stall rst", 1'b0, 66'h0, 0, 0);
        cyc(0, 0, 66'h0, 1, 0, 0);
        check_all("rst_stall rel1", 1'b0, 66'h0, 0, 0);
        cyc(0, 0, 66'h0, 1, 0, 0);
        check_all("rst_stall rel2", 1'b0, 66'h0, 0, 0);

        // Stall while upstream presents 0xCD; ordering preserved afterwards.
        cyc(0, 1, 66'hAB, 1, 0, 0);
        check_all("stall_cd load", 1'b1, 66'hAB, 0, 0);
        for (int i = 0; i < 4; i++) begin
`ifdef PIPE_STAGE_SKID_EN
            cyc(0, (i == 0), 66'hCD, 0, 0, 0);
`else
            cyc(0, 1'b1, 66'hCD, 0, 0, 0);
`endif
            check_all($sformatf("stall_cd s%0d", i), 1'b1, 66'hAB, i + 1, 0);
            check($sformatf("stall_cd s%0d ir", i), ir, 1'b0);
        end
`ifdef PIPE_STAGE_SKID_EN
        cyc(0, 0, 66'hCD, 1, 0, 0);
`else
        cyc(0, 1, 66'hCD, 1, 0, 0);
`endif
        check_all("stall_cd rel", 1'b1, 66'hCD, 4, 0);
        check("stall_cd rel ir", ir, 1'b1);
        cyc(0, 0, 66'h0, 1, 0, 0);
        check_all("stall_cd drain", 1'b0, 66'h0, 4, 0);

        // Flush while stalled with a pending upstream payload: nothing of it
        // may surface afterwards.
        cyc(0, 0, 66'h0, 0, 0, 1);
        cyc(0, 1, 66'h11, 1, 0, 0);
        check_all("flush_pend load", 1'b1, 66'h11, 0, 0);
        cyc(0, 1, 66'h22, 0, 0, 0);
        check_all("flush_pend stall", 1'b1, 66'h11, 1, 0);
        cyc(0, 0, 66'h0, 0, 1, 0);
        check_all("flush_pend flush", 1'b0, 66'h0, 1, 1);
        check("flush_pend ir", ir, 1'b1);
        cyc(0, 0, 66'h0, 1, 0, 0);
        check_all("flush_pend after", 1'b0, 66'h0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
